// File: rtl/mg_pkg.sv
// mg_pkg: shared widths, S-box wiring tables and FSM state type for the MacGuffin round engine.
package mg_pkg;
  localparam int MG_BLOCK_W = 64;
  localparam int MG_WORD_W  = 16;
  localparam int MG_RK_W    = 48;
  localparam int MG_ROUNDS  = 32;

  // Tap t of S-box s drives S-box input bit 5-t; indices address the 48-bit vector {a,b,c}.
  localparam int MG_SBOX_TAPS [8][6] = '{
    '{34, 37, 22, 25, 11, 13},
    '{33, 36, 23, 26,  8, 14},
    '{35, 38, 24, 29,  0, 15},
    '{44, 46, 17, 18,  4, 10},
    '{32, 42, 19, 30,  6, 12},
    '{39, 40, 28, 31,  1,  5},
    '{41, 47, 21, 27,  2,  7},
    '{43, 45, 16, 20,  3,  9}
  };

  // Output bit j of S-box s lands in F bit MG_SBOX_OUT_POS[s][j]; the 16 targets are disjoint.
  localparam int MG_SBOX_OUT_POS [8][2] = '{
    '{0, 5}, '{1, 15}, '{2, 8}, '{3, 10}, '{4, 11}, '{6, 13}, '{7, 12}, '{9, 14}
  };

  // Entry x of S-box s is bits [2x+1:2x] of row s.
  localparam logic [127:0] MG_SBOX_TABLE [8] = '{
    128'h9c3e_4a17_d26b_f085_1e7a_c93d_60b4_f258,
    128'h5b8f_20e6_c47d_a913_3f62_8d0b_e5c1_7a94,
    128'hd1a4_7e39_06cb_f258_8b3f_c1e6_2d74_a590,
    128'h3e96_c0ab_52f7_18d4_a7c1_e36f_9b08_45d2,
    128'h71c8_bd25_e49a_063f_c5e2_1b97_f40d_8a63,
    128'ha65d_f31b_8c07_e492_6e9c_b5a1_d378_0f24,
    128'h48e2_9bd7_31fa_c605_b7d3_04e8_6a1f_c592,
    128'hf07b_6c98_a3d4_25e1_0d4a_e7b3_91c6_8f25
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} mg_state_e;
endpackage

// File: rtl/mg_f_func.sv
// mg_f_func: combinational MacGuffin round function F(R1,R2,R3,rk) built from S-boxes S1..S8.
module mg_sbox
  import mg_pkg::*;
#(
  parameter int SBOX_IDX = 0
) (
  input  logic [5:0] x,
  output logic [1:0] y
);
  localparam logic [127:0] TABLE = MG_SBOX_TABLE[SBOX_IDX];

  assign y = TABLE[{x, 1'b0} +: 2];
endmodule

module mg_f_func
  import mg_pkg::*;
(
  input  logic [MG_WORD_W-1:0] r1,
  input  logic [MG_WORD_W-1:0] r2,
  input  logic [MG_WORD_W-1:0] r3,
  input  logic [MG_RK_W-1:0]   rk,
  output logic [MG_WORD_W-1:0] f
);
  logic [3*MG_WORD_W-1:0]     abc;
  logic [7:0][MG_WORD_W-1:0]  placed;

  assign abc = {r1 ^ rk[47:32], r2 ^ rk[31:16], r3 ^ rk[15:0]};

  for (genvar s = 0; s < 8; s++) begin : g_sbox
    logic [5:0] sin;
    logic [1:0] sout;

    for (genvar t = 0; t < 6; t++) begin : g_tap
      assign sin[5-t] = abc[MG_SBOX_TAPS[s][t]];
    end

    mg_sbox #(.SBOX_IDX(s)) u_sbox (.x(sin), .y(sout));

    assign placed[s] = (MG_WORD_W'(sout[0]) << MG_SBOX_OUT_POS[s][0])
                     | (MG_WORD_W'(sout[1]) << MG_SBOX_OUT_POS[s][1]);
  end

  always_comb begin
    f = '0;
    for (int s = 0; s < 8; s++) f |= placed[s];
  end
endmodule

// File: rtl/macguffin_round_engine.sv
// macguffin_round_engine: iterative MacGuffin encrypt/decrypt, one unbalanced-Feistel round per clock.
// Build option MG_UNROLL2_EN: two rounds per clock, adding the rk_idx2/rk2 key port.
module macguffin_round_engine
  import mg_pkg::*;
#(
  parameter int ROUNDS = MG_ROUNDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MG_BLOCK_W-1:0] in_block,
  input  logic                  in_decrypt,
  output logic [4:0]            rk_idx,
  input  logic [MG_RK_W-1:0]    rk,
`ifdef MG_UNROLL2_EN
  output logic [4:0]            rk_idx2,
  input  logic [MG_RK_W-1:0]    rk2,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MG_BLOCK_W-1:0] out_block
);
`ifdef MG_UNROLL2_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif
  localparam logic [4:0] LAST_CNT = 5'(ROUNDS - STAGES);
  localparam logic [4:0] TOP_IDX  = 5'(ROUNDS - 1);

  mg_state_e                           state_q, state_d;
  logic [MG_BLOCK_W-1:0]               blk_q;
  logic [4:0]                          cnt_q;
  logic                                dec_q;
  logic [STAGES:0][MG_BLOCK_W-1:0]     stage_blk;
  logic [STAGES-1:0][MG_RK_W-1:0]      stage_rk;

  assign stage_blk[0] = blk_q;
  assign stage_rk[0]  = rk;
`ifdef MG_UNROLL2_EN
  assign stage_rk[1]  = rk2;
`endif

  for (genvar st = 0; st < STAGES; st++) begin : g_round
    logic [MG_WORD_W-1:0]   w0, w1, w2, w3, f;
    logic [3*MG_WORD_W-1:0] f_in;

    assign {w0, w1, w2, w3} = stage_blk[st];
    // Decrypt rotates right before mixing, so F sees the three words that precede R3.
    assign f_in = dec_q ? {w0, w1, w2} : {w1, w2, w3};

    mg_f_func u_f (
      .r1 (f_in[47:32]),
      .r2 (f_in[31:16]),
      .r3 (f_in[15:0]),
      .rk (stage_rk[st]),
      .f  (f)
    );

    assign stage_blk[st+1] = dec_q ? {w3 ^ f, w0, w1, w2} : {w1, w2, w3, w0 ^ f};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q <= '0;
      cnt_q <= '0;
      dec_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      unique case (state_q)
        IDLE: if (in_valid) begin
          blk_q <= in_block;
          dec_q <= in_decrypt;
          cnt_q <= '0;
        end
        RUN: begin
          blk_q <= stage_blk[STAGES];
          if (cnt_q != LAST_CNT) cnt_q <= cnt_q + 5'(STAGES);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (latch).
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_block = '0;
    rk_idx    = '0;
`ifdef MG_UNROLL2_EN
    rk_idx2   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        rk_idx  = dec_q ? TOP_IDX - cnt_q : cnt_q;
`ifdef MG_UNROLL2_EN
        rk_idx2 = dec_q ? TOP_IDX - cnt_q - 5'd1 : cnt_q + 5'd1;
`endif
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_block = blk_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/macguffin_round_engine.md
Name: macguffin_round_engine

Overview:
- Iterative MacGuffin datapath; sits directly downstream of the S-box leaf modules (S1..S8) and consumes their 2-bit outputs.
- Holds the 64-bit block as four 16-bit words R0..R3 and runs 32 unbalanced-Feistel rounds, one round per clock.
- Round keys come from an external key store through an index/data port.
- Valid/ready handshake on input and output; supports encrypt and decrypt.

Parameters:
- ROUNDS, 32, number of rounds per block; legal range 2..32, even only.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  block offered
- in_ready  out  1  engine can accept a block
- in_block  in  64  block; R0 = bits 63:48, R3 = bits 15:0
- in_decrypt  in  1  1 = decrypt, sampled with the block
- rk_idx  out  5  round-key index requested this cycle
- rk  in  48  round key for rk_idx, valid in the same cycle (combinational lookup); bits 47:32 = K1, 31:16 = K2, 15:0 = K3
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_block  out  64  result, same word order as in_block

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready = 1, out_valid = 0, out_block = 0, rk_idx = 0, round counter = 0, R0..R3 = 0.
- States:
  - IDLE:
    - in_ready = 1.
    - in_valid & in_ready loads R0..R3, latches the decrypt flag, clears counter i, then goes to RUN.
  - RUN: one round per cycle.
    - rk_idx = i for encrypt, ROUNDS-1-i for decrypt.
    - Encrypt: R0' = R0 ^ F(R1,R2,R3,rk), then rotate words left by one: (R0,R1,R2,R3) <= (R1,R2,R3,R0').
    - Decrypt: rotate right first, (A,B,C,D) = (R3,R0,R1,R2); then A' = A ^ F(B,C,D,rk); registers <= (A',B,C,D).
    - After round ROUNDS-1, go to DONE.
    - in_ready = 0.
  - DONE:
    - out_valid = 1; out_block = {R0,R1,R2,R3}, held stable while out_valid & !out_ready.
    - out_valid & out_ready returns to IDLE; in_ready rises the following cycle, with no same-cycle accept.
- F function:
  - a = R1 ^ K1, b = R2 ^ K2, c = R3 ^ K3.
  - Each of the 8 S-boxes takes a 6-bit input assembled from a, b, c using the tap table MG_SBOX_TAPS.
  - Each S-box's 2-bit output lands in the fixed bit positions given by MG_SBOX_OUT_POS.
  - F = OR of the eight placed 2-bit fields; the fields are disjoint and cover all 16 bits.
- Latency: accept in cycle 0; out_valid asserts in cycle ROUNDS+1; throughput is one block per ROUNDS+2 cycles when the output is never stalled.
- Boundary cases:
  - in_valid while busy is ignored; the source must hold the block until accepted.
  - in_decrypt and in_block change with no effect outside the accept cycle.
  - Reset mid-RUN or mid-DONE aborts immediately; no partial output is ever flagged valid.
  - The counter is 5 bits and never wraps within a block.
  - rk_idx is 0 in IDLE and DONE.

Optional Feature:
- MG_UNROLL2_EN
- Defined:
  - Two rounds per cycle; RUN takes ROUNDS/2 cycles, giving latency ROUNDS/2+1.
  - Adds rk_idx2 (out, 5) and rk2 (in, 48) for the second round of each pair; it instantiates 16 S-boxes.
- Undefined: single-round datapath as above; the rk_idx2/rk2 ports are absent.
- Results are bit-identical either way.

Decomposition:
- Package mg_pkg holds:
  - constants MG_BLOCK_W = 64, MG_WORD_W = 16, MG_RK_W = 48, MG_ROUNDS = 32;
  - MG_SBOX_TAPS [8][6] source-bit indices into {a,b,c};
  - MG_SBOX_OUT_POS [8][2] destination bit indices;
  - state enum {IDLE, RUN, DONE}.
- One natural sub-module: mg_f_func, purely combinational. It takes (R1,R2,R3,rk), produces the 16-bit F, and instantiates S1..S8. The engine instantiates one copy, or two under MG_UNROLL2_EN.

Test Plan:
- Reset: assert rst_n=0 mid-RUN -> out_valid=0, in_ready=1, out_block=0 asynchronously. After release, the next accepted block completes normally.
- Encrypt latency: block 0x0123456789ABCDEF, key store loaded with 32 random keys -> out_valid high exactly 33 cycles after accept; out_block matches the C reference model; rk_idx sequence is 0..31.
- Round trip: feed the encrypt result back with in_decrypt=1 -> out_block = 0x0123456789ABCDEF; rk_idx sequence is 31..0.
- Backpressure: out_ready held 0 for 10 cycles in DONE -> out_block stable, out_valid held, in_valid ignored (in_ready=0). Release out_ready -> in_ready=1 on the next cycle.
- F isolation: all-zero keys, in_block=0, ROUNDS=2 -> output equals the model's two-round value; each S-box's output is visible in its MG_SBOX_OUT_POS bits only.
- MG_UNROLL2_EN build: 1000 random blocks/keys -> results identical to the default build; latency is 17 cycles.
